// File: rtl/sdram_tester_pkg.sv
// Shared types and constants for the SDRAM traffic tester: FSM encoding,
// pattern modes, LFSR polynomial and the Galois LFSR step.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_WALK = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_INV  = 2'd3;

  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int          ERR_CNT_W = 16;

  // Right-shifting Galois form: feedback taps applied when the bit shifted out is 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_POLY : {LFSR_W{1'b0}});
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational data-pattern generator: maps (mode, index, LFSR state) to the
// test word and the LFSR state to use for the following word.
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 11
) (
  input  logic [1:0]            i_mode,
  input  logic [IDX_W-1:0]      i_index,
  input  logic [LFSR_W-1:0]     i_lfsr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [LFSR_W-1:0]     o_lfsr_next
);

  logic [DATA_WIDTH-1:0] w_index;
  logic [31:0]           w_bit_pos;

  assign w_index     = DATA_WIDTH'(i_index);
  assign w_bit_pos   = 32'(i_index) % 32'(DATA_WIDTH);
  assign o_lfsr_next = lfsr_step(i_lfsr);

  // Pattern select
  always_comb begin
    o_data = '0;
    case (i_mode)
      MODE_ADDR: o_data = w_index;
      MODE_WALK: o_data = DATA_WIDTH'(1'b1) << w_bit_pos;
      MODE_LFSR: o_data = DATA_WIDTH'(i_lfsr);
      MODE_INV:  o_data = ~w_index;
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/sdram_traffic_tester.sv
// Write-then-read-back traffic generator/checker for the SoC side of
// sdram_controller; reports pass/fail, error count and first-failure details.
module sdram_traffic_tester
  import sdram_tester_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 23,
  parameter int          DATA_WIDTH     = 32,
  parameter int          MASK_WIDTH     = 4,
  parameter int unsigned START_ADDR     = 32'd0,
  parameter int          WORD_COUNT     = 1024,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] LFSR_SEED      = 32'hACE1_2B3D
) (
  input  logic                  clk,
  input  logic                  reset_port,
  input  logic                  start_port,
  input  logic [1:0]            mode_port,
  input  logic                  stop_on_error_port,
  output logic                  running_port,
  output logic                  done_port,
  output logic                  pass_port,
  output logic                  timeout_port,
  output logic [ERR_CNT_W-1:0]  error_count_port,
  output logic [ADDR_WIDTH-1:0] first_err_addr_port,
  output logic [DATA_WIDTH-1:0] first_err_expected_port,
  output logic [DATA_WIDTH-1:0] first_err_actual_port,
  input  logic                  soc_side_busy_port,
  input  logic                  soc_side_ready_port,
  input  logic [DATA_WIDTH-1:0] soc_side_rd_data_port,
  output logic [ADDR_WIDTH-1:0] soc_side_addr_port,
  output logic [DATA_WIDTH-1:0] soc_side_wr_data_port,
  output logic [MASK_WIDTH-1:0] soc_side_wr_mask_port,
  output logic                  soc_side_wr_en_port,
  output logic                  soc_side_rd_en_port
);

  localparam int                    IDX_W    = $clog2(WORD_COUNT + 1);
  localparam int                    TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORD_COUNT - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(START_ADDR);

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [IDX_W-1:0]      r_idx;
  logic [LFSR_W-1:0]     r_lfsr;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic                  r_seen_busy;
  logic                  r_running;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_timeout;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [DATA_WIDTH-1:0] r_err_exp;
  logic [DATA_WIDTH-1:0] r_err_act;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en;
  logic                  r_rd_en;

  logic [DATA_WIDTH-1:0] w_data;
  logic [LFSR_W-1:0]     w_lfsr_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_mismatch;
  logic                  w_tmo_hit;
  logic                  w_stall;

  sdram_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_pattern (
    .i_mode      (r_mode),
    .i_index     (r_idx),
    .i_lfsr      (r_lfsr),
    .o_data      (w_data),
    .o_lfsr_next (w_lfsr_next)
  );

  assign w_addr     = BASE + ADDR_WIDTH'(r_idx);
  assign w_mismatch = (soc_side_rd_data_port != w_data);
  assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

  // A stalled cycle is one spent in an issue/wait state without making progress.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_WR_ISSUE, ST_RD_ISSUE: w_stall = soc_side_busy_port;
      ST_WR_WAIT:               w_stall = !(r_seen_busy && !soc_side_busy_port);
      ST_RD_WAIT:               w_stall = !soc_side_ready_port;
      default:                  w_stall = 1'b0;
    endcase
  end

  // Tester FSM with registered request and result outputs
  always_ff @(posedge clk) begin
    if (reset_port) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_ADDR;
      r_idx       <= '0;
      r_lfsr      <= '0;
      r_tmo_cnt   <= '0;
      r_seen_busy <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_err_addr  <= '0;
      r_err_exp   <= '0;
      r_err_act   <= '0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_port) begin
            r_running  <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_act  <= '0;
            r_idx      <= '0;
            r_lfsr     <= LFSR_SEED;
            r_mode     <= mode_port;
            r_tmo_cnt  <= '0;
            r_state    <= ST_WR_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          if (!w_stall) begin
            r_wr_en     <= 1'b1;
            r_addr      <= w_addr;
            r_wr_data   <= w_data;
            r_lfsr      <= w_lfsr_next;
            r_seen_busy <= 1'b0;
            r_tmo_cnt   <= '0;
            r_state     <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (soc_side_busy_port) begin
            r_seen_busy <= 1'b1;
          end
          if (!w_stall) begin
            r_tmo_cnt <= '0;
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_lfsr  <= LFSR_SEED;
              r_state <= ST_RD_ISSUE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_WR_ISSUE;
            end
          end
        end
        ST_RD_ISSUE: begin
          if (!w_stall) begin
            r_rd_en   <= 1'b1;
            r_addr    <= w_addr;
            r_tmo_cnt <= '0;
            r_state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (!w_stall) begin
            r_lfsr    <= w_lfsr_next;
            r_tmo_cnt <= '0;
            if (w_mismatch) begin
              if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
              end
              if (r_err_cnt == '0) begin
                r_err_addr <= r_addr;
                r_err_exp  <= w_data;
                r_err_act  <= soc_side_rd_data_port;
              end
            end
            if ((w_mismatch && stop_on_error_port) || (r_idx == LAST_IDX)) begin
              r_running <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= (r_err_cnt == '0) && !w_mismatch;
              r_state   <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_RD_ISSUE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // The per-transaction watchdog overrides whatever the state branch chose.
      if (w_stall) begin
        if (w_tmo_hit) begin
          r_timeout <= 1'b1;
          r_running <= 1'b0;
          r_done    <= 1'b1;
          r_pass    <= 1'b0;
          r_wr_en   <= 1'b0;
          r_rd_en   <= 1'b0;
          r_state   <= ST_DONE;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

  assign running_port            = r_running;
  assign done_port               = r_done;
  assign pass_port               = r_pass;
  assign timeout_port            = r_timeout;
  assign error_count_port        = r_err_cnt;
  assign first_err_addr_port     = r_err_addr;
  assign first_err_expected_port = r_err_exp;
  assign first_err_actual_port   = r_err_act;
  assign soc_side_addr_port      = r_addr;
  assign soc_side_wr_data_port   = r_wr_data;
  assign soc_side_wr_mask_port   = '0;
  assign soc_side_wr_en_port     = r_wr_en;
  assign soc_side_rd_en_port     = r_rd_en;

endmodule
